// File: rtl/mem_bridge.sv
// Core-side memory bridge: classifies core requests, drives one byte-enabled
// cyc/ack bus cycle at a time, and returns extended read data or a fault code.
module mem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        sys_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wr_data,
    input  logic [2:0]  i_rd_mask,
    input  logic [1:0]  i_wr_mask,
    output logic        o_ack,
    output logic [31:0] o_rd_data,
    output logic        o_fault,
    output logic [1:0]  o_fault_code,
    output logic        o_busy,
    output logic        o_bus_cyc,
    output logic        o_bus_we,
    output logic [29:0] o_bus_addr,
    output logic [3:0]  o_bus_sel,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic        i_bus_err,
    input  logic [31:0] i_bus_rdata
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [1:0] FC_NONE  = 2'd0;
    localparam logic [1:0] FC_ALIGN = 2'd1;
    localparam logic [1:0] FC_BUS   = 2'd2;
    localparam logic [1:0] FC_TMO   = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t         state_q, state_d;
    logic           ack_q, ack_d, fault_q, fault_d, busy_q, busy_d;
    logic [1:0]     code_q, code_d, pend_q, pend_d, lo_q, lo_d;
    logic [31:0]    rd_data_q, rd_data_d, wdata_q, wdata_d;
    logic           cyc_q, cyc_d, we_q, we_d;
    logic [29:0]    addr_q, addr_d;
    logic [3:0]     sel_q, sel_d;
    logic [2:0]     rdm_q, rdm_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    // Request classification, evaluated on the raw core inputs while idle
    logic       rd_act_c, wr_act_c, is_w_c, is_h_c, fast_c, timeout_c;
    logic [1:0] fast_code_c;
    logic [3:0] sel_c;
    logic [31:0] wdata_c, ext_c;
    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        rd_act_c = (i_rd_mask != 3'd0) && (i_rd_mask < 3'd6);
        wr_act_c = (i_wr_mask != 2'd0);
        is_w_c   = rd_act_c ? (i_rd_mask == 3'd1) : (i_wr_mask == 2'd1);
        is_h_c   = rd_act_c ? (i_rd_mask == 3'd2 || i_rd_mask == 3'd3) : (i_wr_mask == 2'd2);
        fast_c      = 1'b1;
        fast_code_c = FC_NONE;
        if (rd_act_c && wr_act_c) begin
            fast_code_c = FC_ALIGN;
        end else if (!rd_act_c && !wr_act_c) begin
            fast_code_c = FC_NONE;
        end else if ((is_w_c && i_addr[1:0] != 2'b00) || (is_h_c && i_addr[0])) begin
            fast_code_c = FC_ALIGN;
        end else begin
            fast_c = 1'b0;
        end
        if (is_w_c) begin
            sel_c   = 4'b1111;
            wdata_c = i_wr_data;
        end else if (is_h_c) begin
            sel_c   = i_addr[1] ? 4'b1100 : 4'b0011;
            wdata_c = {2{i_wr_data[15:0]}};
        end else begin
            sel_c   = 4'b0001 << i_addr[1:0];
            wdata_c = {4{i_wr_data[7:0]}};
        end
    end

    // Load lane extraction and extension from the latched size/offset
    always_comb begin
        case (lo_q)
            2'd0:    byte_c = i_bus_rdata[7:0];
            2'd1:    byte_c = i_bus_rdata[15:8];
            2'd2:    byte_c = i_bus_rdata[23:16];
            default: byte_c = i_bus_rdata[31:24];
        endcase
        half_c = lo_q[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
        case (rdm_q)
            3'd1:    ext_c = i_bus_rdata;
            3'd2:    ext_c = {{16{half_c[15]}}, half_c};
            3'd3:    ext_c = {16'd0, half_c};
            3'd4:    ext_c = {{24{byte_c[7]}}, byte_c};
            3'd5:    ext_c = {24'd0, byte_c};
            default: ext_c = 32'd0;
        endcase
    end

    assign timeout_c = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sys_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (i_req) state_d = fast_c ? S_RESP : S_BUS;
            S_BUS:  if (i_bus_err || i_bus_ack || timeout_c) state_d = S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

    // Fast-path RESP raises o_ack on its exit edge; bus termination raises it directly
    always_comb begin
        ack_d     = 1'b0;
        fault_d   = 1'b0;
        code_d    = FC_NONE;
        busy_d    = (state_d != S_IDLE);
        rd_data_d = rd_data_q;
        cyc_d     = cyc_q;
        we_d      = we_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        lo_d      = lo_q;
        rdm_d     = rdm_q;
        pend_d    = pend_q;
        case (state_q)
            S_IDLE: begin
                if (i_req) begin
                    lo_d   = i_addr[1:0];
                    rdm_d  = i_rd_mask;
                    pend_d = fast_code_c;
                    cnt_d  = '0;
                    if (!fast_c) begin
                        cyc_d   = 1'b1;
                        we_d    = wr_act_c;
                        addr_d  = i_addr[31:2];
                        sel_d   = sel_c;
                        wdata_d = wdata_c;
                    end
                end
            end
            S_BUS: begin
                if (i_bus_err || i_bus_ack || timeout_c) begin
                    ack_d     = 1'b1;
                    cyc_d     = 1'b0;
                    we_d      = 1'b0;
                    sel_d     = 4'd0;
                    rd_data_d = 32'd0;
                    if (i_bus_err) begin
                        fault_d = 1'b1;
                        code_d  = FC_BUS;
                    end else if (i_bus_ack) begin
                        rd_data_d = ext_c;
                    end else begin
                        fault_d = 1'b1;
                        code_d  = FC_TMO;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                if (!ack_q) begin
                    ack_d     = 1'b1;
                    fault_d   = (pend_q != FC_NONE);
                    code_d    = pend_q;
                    rd_data_d = 32'd0;
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge i_reset) begin
        if (i_reset) begin
            ack_q     <= 1'b0;
            fault_q   <= 1'b0;
            code_q    <= FC_NONE;
            busy_q    <= 1'b0;
            rd_data_q <= 32'd0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 30'd0;
            sel_q     <= 4'd0;
            wdata_q   <= 32'd0;
            cnt_q     <= '0;
            lo_q      <= 2'd0;
            rdm_q     <= 3'd0;
            pend_q    <= FC_NONE;
        end else begin
            ack_q     <= ack_d;
            fault_q   <= fault_d;
            code_q    <= code_d;
            busy_q    <= busy_d;
            rd_data_q <= rd_data_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            lo_q      <= lo_d;
            rdm_q     <= rdm_d;
            pend_q    <= pend_d;
        end
    end

    assign o_ack        = ack_q;
    assign o_rd_data    = rd_data_q;
    assign o_fault      = fault_q;
    assign o_fault_code = code_q;
    assign o_busy       = busy_q;
    assign o_bus_cyc    = cyc_q;
    assign o_bus_we     = we_q;
    assign o_bus_addr   = addr_q;
    assign o_bus_sel    = sel_q;
    assign o_bus_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Directed bench for mem_bridge: lane steering, extension, faults, timeout, reset abort.
module tb_mem_bridge;

    logic        sys_clk;
    logic        i_reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_wr_data;
    logic [2:0]  i_rd_mask;
    logic [1:0]  i_wr_mask;
    logic        o_ack;
    logic [31:0] o_rd_data;
    logic        o_fault;
    logic [1:0]  o_fault_code;
    logic        o_busy;
    logic        o_bus_cyc;
    logic        o_bus_we;
    logic [29:0] o_bus_addr;
    logic [3:0]  o_bus_sel;
    logic [31:0] o_bus_wdata;
    logic        i_bus_ack;
    logic        i_bus_err;
    logic [31:0] i_bus_rdata;

    int checks = 0;
    int errors = 0;

    mem_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .sys_clk(sys_clk), .i_reset(i_reset), .i_req(i_req), .i_addr(i_addr),
        .i_wr_data(i_wr_data), .i_rd_mask(i_rd_mask), .i_wr_mask(i_wr_mask),
        .o_ack(o_ack), .o_rd_data(o_rd_data), .o_fault(o_fault),
        .o_fault_code(o_fault_code), .o_busy(o_busy), .o_bus_cyc(o_bus_cyc),
        .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr), .o_bus_sel(o_bus_sel),
        .o_bus_wdata(o_bus_wdata), .i_bus_ack(i_bus_ack), .i_bus_err(i_bus_err),
        .i_bus_rdata(i_bus_rdata)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    task automatic drive_req(input logic [31:0] a, input logic [31:0] wd,
                             input logic [2:0] rm, input logic [1:0] wm);
        i_req = 1'b1; i_addr = a; i_wr_data = wd; i_rd_mask = rm; i_wr_mask = wm;
        tick();
        i_req = 1'b0; i_addr = 32'hFFFF_FFFF; i_wr_data = 32'h5555_5555;
        i_rd_mask = 3'd0; i_wr_mask = 2'd0;
    endtask

    // One bus transaction; the slave responds in BUS cycle 'dly'
    task automatic bus_txn(input string tag, input logic [31:0] a, input logic [31:0] wd,
                           input logic [2:0] rm, input logic [1:0] wm, input int dly,
                           input logic ack, input logic err, input logic [31:0] rdata,
                           input logic [3:0] esel, input logic [31:0] ewd,
                           input logic [31:0] erd, input logic [1:0] ecode);
        drive_req(a, wd, rm, wm);
        chk({tag, " cyc"}, 32'(o_bus_cyc), 32'd1);
        chk({tag, " we"}, 32'(o_bus_we), 32'(wm != 2'd0));
        chk({tag, " addr"}, 32'(o_bus_addr), 32'(a[31:2]));
        chk({tag, " sel"}, 32'(o_bus_sel), 32'(esel));
        if (wm != 2'd0) chk({tag, " wdata"}, o_bus_wdata, ewd);
        for (int i = 1; i < dly; i++) begin
            tick();
            chk({tag, " hold"}, 32'({o_bus_cyc, o_bus_sel, o_ack}), 32'({1'b1, esel, 1'b0}));
        end
        i_bus_ack = ack; i_bus_err = err; i_bus_rdata = rdata;
        tick();
        i_bus_ack = 1'b0; i_bus_err = 1'b0; i_bus_rdata = 32'h0BAD_F00D;
        chk({tag, " ack"}, 32'({o_ack, o_bus_cyc}), 32'({1'b1, 1'b0}));
        chk({tag, " fault"}, 32'({o_fault, o_fault_code}), 32'({ecode != 2'd0, ecode}));
        chk({tag, " rdata"}, o_rd_data, erd);
        tick();
        chk({tag, " post"}, 32'({o_ack, o_fault, o_fault_code, o_busy}), 32'd0);
        chk({tag, " rdata hold"}, o_rd_data, erd);
    endtask

    // Request that never reaches the bus: o_ack two cycles after i_req
    task automatic fast_txn(input string tag, input logic [31:0] a, input logic [2:0] rm,
                            input logic [1:0] wm, input logic [1:0] ecode);
        drive_req(a, 32'h1234_5678, rm, wm);
        chk({tag, " n+1"}, 32'({o_ack, o_bus_cyc, o_busy}), 32'({1'b0, 1'b0, 1'b1}));
        tick();
        chk({tag, " ack"}, 32'({o_ack, o_bus_cyc}), 32'({1'b1, 1'b0}));
        chk({tag, " fault"}, 32'({o_fault, o_fault_code}), 32'({ecode != 2'd0, ecode}));
        chk({tag, " rdata"}, o_rd_data, 32'd0);
        tick();
        chk({tag, " post"}, 32'({o_ack, o_busy}), 32'd0);
    endtask

    initial begin
        int cyc_cnt;
        logic seen_ack;
        i_reset = 1'b1; i_req = 1'b0; i_addr = '0; i_wr_data = '0;
        i_rd_mask = '0; i_wr_mask = '0; i_bus_ack = 1'b0; i_bus_err = 1'b0;
        i_bus_rdata = '0;
        #1;
        chk("reset outs", 32'({o_ack, o_fault, o_fault_code, o_busy, o_bus_cyc, o_bus_we, o_bus_sel}), 32'd0);
        chk("reset rdata", o_rd_data, 32'd0);
        chk("reset wdata", o_bus_wdata | 32'(o_bus_addr), 32'd0);
        tick(); tick();
        i_reset = 1'b0;
        tick();

        bus_txn("st_b", 32'h102, 32'h0000_00A5, 3'd0, 2'd3, 3, 1'b1, 1'b0, 32'h0,
                4'b0100, 32'hA5A5_A5A5, 32'd0, 2'd0);
        bus_txn("st_h", 32'h2, 32'h1234_ABCD, 3'd0, 2'd2, 1, 1'b1, 1'b0, 32'h0,
                4'b1100, 32'hABCD_ABCD, 32'd0, 2'd0);
        bus_txn("ld_bs", 32'h203, 32'h0, 3'd4, 2'd0, 2, 1'b1, 1'b0, 32'h8011_2233,
                4'b1000, 32'h0, 32'hFFFF_FF80, 2'd0);
        bus_txn("ld_bu", 32'h203, 32'h0, 3'd5, 2'd0, 1, 1'b1, 1'b0, 32'h8011_2233,
                4'b1000, 32'h0, 32'h0000_0080, 2'd0);
        bus_txn("ld_hu", 32'h12, 32'h0, 3'd3, 2'd0, 1, 1'b1, 1'b0, 32'hBEEF_1234,
                4'b1100, 32'h0, 32'h0000_BEEF, 2'd0);
        bus_txn("ld_hs", 32'h12, 32'h0, 3'd2, 2'd0, 2, 1'b1, 1'b0, 32'hBEEF_1234,
                4'b1100, 32'h0, 32'hFFFF_BEEF, 2'd0);
        bus_txn("ld_b1", 32'h81, 32'h0, 3'd5, 2'd0, 1, 1'b1, 1'b0, 32'h1122_3344,
                4'b0010, 32'h0, 32'h0000_0033, 2'd0);
        bus_txn("ackerr", 32'h20, 32'h0, 3'd1, 2'd0, 1, 1'b1, 1'b1, 32'h7777_7777,
                4'b1111, 32'h0, 32'd0, 2'd2);

        fast_txn("misalign_w", 32'h6, 3'd1, 2'd0, 2'd1);
        fast_txn("misalign_h", 32'h11, 3'd0, 2'd2, 2'd1);
        fast_txn("illegal", 32'h0, 3'd1, 2'd1, 2'd1);
        fast_txn("none", 32'h40, 3'd6, 2'd0, 2'd0);

        // Silent slave: cycle stays up for exactly TIMEOUT_CYCLES cycles
        drive_req(32'h100, 32'h0, 3'd1, 2'd0);
        cyc_cnt = 0;
        seen_ack = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (o_bus_cyc) cyc_cnt++;
            if (o_ack) begin
                seen_ack = 1'b1;
                break;
            end
            tick();
        end
        chk("tmo ack seen", 32'(seen_ack), 32'd1);
        chk("tmo cyc count", 32'(cyc_cnt), 32'd8);
        chk("tmo fault", 32'({o_fault, o_fault_code, o_busy}), 32'({1'b1, 2'd3, 1'b1}));
        chk("tmo rdata", o_rd_data, 32'd0);
        tick();
        chk("tmo post", 32'({o_ack, o_busy}), 32'd0);

        // Reset in the second BUS cycle aborts without an acknowledge
        drive_req(32'h40, 32'h0, 3'd1, 2'd0);
        tick();
        chk("rst pre", 32'({o_bus_cyc, o_busy}), 32'({1'b1, 1'b1}));
        #1 i_reset = 1'b1;
        i_bus_ack = 1'b1;
        #1;
        chk("rst imm", 32'({o_bus_cyc, o_busy, o_ack}), 32'd0);
        @(negedge sys_clk);
        i_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst no ack", 32'({o_ack, o_bus_cyc, o_busy}), 32'd0);
        end
        i_bus_ack = 1'b0;
        bus_txn("after_rst", 32'h0, 32'h0, 3'd1, 2'd0, 1, 1'b1, 1'b0, 32'hDEAD_BEEF,
                4'b1111, 32'h0, 32'hDEAD_BEEF, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bridge.md
Name: mem_bridge

Overview:
- Memory bridge directly downstream of the Argon core's memory port.
- Takes the core's address, write data and read/write masks, and drives a single-outstanding, byte-enabled bus with cyc/ack handshake.
- Handles lane steering, sign/zero extension of loads, alignment checks and bus timeout.
- Returns registered read data plus a one-cycle acknowledge/fault to the core.

Parameters:
TIMEOUT_CYCLES, 64, number of BUS-state cycles without i_bus_ack/i_bus_err before a timeout fault (minimum 2)

Ports:
sys_clk  input  1  clock; all state changes on rising edge
i_reset  input  1  asynchronous, active-high reset
i_req  input  1  core request strobe; sampled only in IDLE
i_addr  input  32  byte address
i_wr_data  input  32  store data, right-justified
i_rd_mask  input  3  0 none, 1 W, 2 H signed, 3 H unsigned, 4 B signed, 5 B unsigned, 6/7 treated as none
i_wr_mask  input  2  0 none, 1 W, 2 H, 3 B
o_ack  output  1  one-cycle completion pulse to core
o_rd_data  output  32  extended load result, valid when o_ack=1
o_fault  output  1  fault flag, valid when o_ack=1
o_fault_code  output  2  0 none, 1 misaligned/illegal, 2 bus error, 3 timeout
o_busy  output  1  high in any state other than IDLE
o_bus_cyc  output  1  bus cycle active
o_bus_we  output  1  1 write, 0 read
o_bus_addr  output  30  word address, i_addr[31:2]
o_bus_sel  output  4  byte lane enables, lane n = bits [8n+7:8n] (little-endian)
o_bus_wdata  output  32  lane-replicated store data
i_bus_ack  input  1  slave completion
i_bus_err  input  1  slave error completion
i_bus_rdata  input  32  slave read data, valid with i_bus_ack

Behaviour:
- Reset (async, immediate) drives every output to 0; state goes to IDLE and the timeout counter to 0. A reset mid-cycle drops o_bus_cyc at once and never produces o_ack for the aborted request.
- States: IDLE, BUS, RESP.
- IDLE, i_req=0: no action.
- IDLE, i_req=1: latch address, masks, data and size. Classify the request:
  - Both masks non-zero → illegal: RESP with fault code 1. No bus cycle.
  - Both masks none → RESP with no fault and o_rd_data=0. No bus cycle.
  - Misaligned (W with addr[1:0]≠0, H with addr[0]=1) → RESP with fault code 1. No bus cycle.
  - Otherwise → BUS. o_bus_cyc, o_bus_we, o_bus_addr, o_bus_sel and o_bus_wdata are registered and valid in the first BUS cycle.
- Lane rules:
  - o_bus_sel: W=1111; H=0011 when addr[1]=0, 1100 when addr[1]=1; B=0001<<addr[1:0].
  - o_bus_wdata: W = data; H = {2{data[15:0]}}; B = {4{data[7:0]}}.
  - Reads use the same o_bus_sel. Data is extracted from lane addr[1:0] (or halfword addr[1]) and sign- or zero-extended per the mask.
- BUS: outputs held stable. Counter increments each cycle.
  - i_bus_err=1 → RESP with fault code 2. Error wins over a simultaneous ack.
  - Else i_bus_ack=1 → capture the extended read data → RESP with no fault.
  - Else counter == TIMEOUT_CYCLES-1 → RESP with fault code 3.
  - o_bus_cyc deasserts in the cycle after the terminating event.
- RESP: o_ack=1 for exactly one cycle, with o_rd_data, o_fault and o_fault_code valid. Next state IDLE.
  - o_rd_data is 0 for writes and for all faults.
  - o_ack, o_fault and o_fault_code return to 0 in the following cycle; o_rd_data holds its value until the next RESP.
- Latency:
  - Fast path (no bus cycle): i_req at cycle N → o_ack at N+2.
  - Bus path: i_bus_ack at cycle M → o_ack at M+1.
- i_req outside IDLE is ignored, with no queueing. Input changes after the latch cycle have no effect.
- i_bus_ack/i_bus_err while o_bus_cyc=0 are ignored.
- Counter resets to 0 on every entry to BUS and never wraps.

Test Plan:
1. Byte store: i_addr=0x102, i_wr_data=0x000000A5, wr_mask=B, slave acks after 3 cycles → o_bus_addr=0x40, o_bus_sel=0100, o_bus_wdata=0xA5A5A5A5, we=1; o_ack one cycle after ack with o_fault=0.
2. Signed byte load: i_addr=0x203, rd_mask=4, i_bus_rdata=0x80112233 → o_bus_sel=1000, o_rd_data=0xFFFFFF80. Repeat with rd_mask=5 → 0x00000080.
3. Halfword load: i_addr=0x12, rd_mask=3, rdata=0xBEEF1234 → o_bus_sel=1100, o_rd_data=0x0000BEEF. With rd_mask=2 → 0xFFFFBEEF.
4. Faults:
   - Word load at 0x6 → no o_bus_cyc; o_ack at N+2 with fault code 1.
   - rd_mask=1 and wr_mask=1 together → fault code 1.
   - Slave asserts ack and err in the same cycle → fault code 2, o_rd_data=0.
5. Timeout: TIMEOUT_CYCLES=8, slave silent → o_bus_cyc high exactly 8 cycles, then o_ack with fault code 3, o_busy low the cycle after.
6. Reset mid-BUS: assert i_reset in the 2nd BUS cycle → o_bus_cyc and o_busy low immediately, no o_ack. A following word read at 0x0 completes normally.
